ballot_rx: RTL and testbench
============================

# ballot_rx

Serial ballot receiver that sits directly upstream of the weighted vote counter. It deserialises voter-ID frames from a single-bit line and validates them. Accepted IDs are latched into sticky one-hot presence vectors (`np`, `vip`, `vvip`), which drive the counter's inputs. Malformed, out-of-range and duplicate frames are counted and never reach the vectors.

## Interface
- `CNT_W`, 8, width of the saturating error and duplicate counters
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high; clears all state
- `clr`  in  1  synchronous clear; vectors, counters and FSM return to reset state
- `sin`  in  1  serial ballot line; idles high
- `np`  out  32  sticky presence, ordinary voters ID 0–31
- `vip`  out  8  sticky presence, VIP voters ID 32–39
- `vvip`  out  1  sticky presence, VVIP voter ID 40
- `busy`  out  1  high while FSM is not IDLE
- `frame_ok`  out  1  one-cycle pulse: frame accepted, new ID latched
- `frame_err`  out  1  one-cycle pulse: frame rejected
- `dup_cnt`  out  CNT_W  saturating count of well-formed frames whose ID was already present
- `err_cnt`  out  CNT_W  saturating count of rejected frames

## Operation
- Frame: start bit 0, then 6 data bits LSB first, then the parity bit (only if `BALLOT_PARITY_EN`), then stop bit 1. One bit per clock; no oversampling.
- FSM states and transitions:
  - IDLE: `sin`=0 → DATA.
  - DATA: 6 cycles, with a 3-bit index that shifts data into `id_sh`. Then → PARITY (parity build) or → STOP.
  - PARITY: 1 cycle, even parity. The bit is captured and the FSM → STOP.
  - STOP: evaluates the frame and → IDLE.
- Evaluation at STOP, in priority order:
  1. Stop bit is 0, or parity is wrong: reject.
  2. ID ≥ 41: reject.
  3. Presence bit already set: duplicate. `dup_cnt`+1, no pulse.
  4. Otherwise set the bit and pulse `frame_ok`.
- A reject increments `err_cnt` and pulses `frame_err`.
- Counters saturate at 2^CNT_W−1; they never wrap.
- Presence bits are only ever set, never cleared, except by `reset` or `clr`.
- A bad stop bit returns the FSM to IDLE. If `sin` is still 0 in IDLE, that cycle is taken as a new start bit.
- `clr` and frame evaluation in the same cycle: `clr` wins. The frame is dropped with no pulse and no counter change.
- `clr` or `reset` mid-frame: the partial frame is discarded, FSM → IDLE.
- Reset values: all vectors 0, counters 0, `busy`/`frame_ok`/`frame_err` 0, FSM IDLE.

## Timing
- Let T0 be the cycle in which the start bit is sampled. Data bits are sampled at T1–T6.
- With parity: parity at T7, stop at T8. Vector, counter and pulse updates are visible from T9.
- Without parity: stop at T7, updates visible from T8.
- `busy` is high from T1 through the stop cycle inclusive.
- Back-to-back frames: the next start bit may arrive in the cycle immediately after the stop cycle. There are no gap cycles.
- All outputs are registered. No combinational path from `sin` to any output.

## Configuration
- `BALLOT_PARITY_EN` defined: 9-bit frame body with the PARITY state. A bad parity bit is a reject.
- Undefined: PARITY state and parity logic are absent, and the frame is 8 bits total.

## Test plan
- ID 5 (data 1,0,1,0,0,0; parity 0; stop 1) → `np`=32'h0000_0020, one `frame_ok` pulse at T9, `err_cnt`=0.
- ID 33 then ID 40 back-to-back → `vip`=8'h02, `vvip`=1, two `frame_ok` pulses 9 cycles apart.
- ID 5 sent twice → `np` unchanged after the second frame, `dup_cnt`=1, no second `frame_ok`.
- ID 45, then ID 5 with flipped parity, then ID 7 with stop=0 → `err_cnt`=3, three `frame_err` pulses, all vectors 0.
- Assert `clr` in the stop cycle of ID 9 after prior ID 3 → vectors all 0, counters 0, no pulse. Then ID 9 resent → `np`=32'h0000_0200.
- 300 rejected frames → `err_cnt` holds at 255. Assert `reset` mid-DATA → all outputs 0 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/ballot_rx_if.sv
// Ballot receiver bus: serial line and clear in, presence vectors and status out.
// Latency: n/a (signal bundle only). Backpressure: none, the serial line cannot be stalled.
// Signals: clr, sin (to receiver); np, vip, vvip, busy, frame_ok, frame_err,
//          dup_cnt, err_cnt (from receiver). master = line/host side, slave = receiver.
interface ballot_rx_if #(
  parameter int CNT_W = 8
);
  logic             clr;
  logic             sin;
  logic [31:0]      np;
  logic [7:0]       vip;
  logic             vvip;
  logic             busy;
  logic             frame_ok;
  logic             frame_err;
  logic [CNT_W-1:0] dup_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output clr, sin,
    input  np, vip, vvip, busy, frame_ok, frame_err, dup_cnt, err_cnt
  );

  modport slave (
    input  clr, sin,
    output np, vip, vvip, busy, frame_ok, frame_err, dup_cnt, err_cnt
  );
endinterface

// File: rtl/ballot_rx.sv
// Serial ballot receiver: deserialises 6-bit voter IDs and latches them into sticky presence vectors.
// Latency: results visible the cycle after the stop bit (T9 with parity, T8 without); all outputs registered.
// Backpressure: none; one bit per clock, back-to-back frames accepted with zero gap.
// Ports: clk, reset (async, active-high), bus (ballot_rx_if.slave: clr, sin in; np, vip, vvip,
//        busy, frame_ok, frame_err, dup_cnt, err_cnt out).
// Build option: define BALLOT_PARITY_EN to add an even-parity bit between data and stop.
module ballot_rx #(
  parameter int CNT_W = 8
) (
  input logic        clk,
  input logic        reset,
  ballot_rx_if.slave bus
);

`ifdef BALLOT_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
  } state_t;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [5:0]       N_IDS   = 6'd41;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0]       id_sh_q, id_sh_d;
  logic [40:0]      pres_q, pres_d;
  logic [CNT_W-1:0] dup_q, dup_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             ok_q, ok_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;
  logic             frame_bad;
  logic [40:0]      id_bit;

  // IDs >= 41 shift out of the vector entirely; they are rejected before use anyway.
  assign id_bit = 41'd1 << id_sh_q;

`ifdef BALLOT_PARITY_EN
  logic par_q, par_d;
  // Even parity: the captured bit must equal the XOR of the six data bits.
  assign frame_bad = ~bus.sin | (par_q ^ (^id_sh_q));
`else
  assign frame_bad = ~bus.sin;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    id_sh_d = id_sh_q;
    pres_d  = pres_q;
    dup_d   = dup_q;
    err_d   = err_q;
    ok_d    = 1'b0;
    ferr_d  = 1'b0;
`ifdef BALLOT_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!bus.sin) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        // LSB arrives first, so shift in from the top; after six bits bit 0 is the first one.
        id_sh_d = {bus.sin, id_sh_q[5:1]};
        if (idx_q == 3'd5) begin
          idx_d = 3'd0;
`ifdef BALLOT_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
`ifdef BALLOT_PARITY_EN
      S_PARITY: begin
        par_d   = bus.sin;
        state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // A bad stop bit also lands here; IDLE then treats a still-low line as a fresh start.
        state_d = S_IDLE;
        if (frame_bad || (id_sh_q >= N_IDS)) begin
          ferr_d = 1'b1;
          if (err_q != CNT_MAX) err_d = err_q + CNT_W'(1);
        end else if ((pres_q & id_bit) != '0) begin
          if (dup_q != CNT_MAX) dup_d = dup_q + CNT_W'(1);
        end else begin
          pres_d = pres_q | id_bit;
          ok_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clear overrides everything, including a frame being evaluated this cycle.
    if (bus.clr) begin
      state_d = S_IDLE;
      idx_d   = 3'd0;
      id_sh_d = 6'd0;
      pres_d  = '0;
      dup_d   = '0;
      err_d   = '0;
      ok_d    = 1'b0;
      ferr_d  = 1'b0;
`ifdef BALLOT_PARITY_EN
      par_d   = 1'b0;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      id_sh_q <= 6'd0;
      pres_q  <= '0;
      dup_q   <= '0;
      err_q   <= '0;
      ok_q    <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef BALLOT_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      id_sh_q <= id_sh_d;
      pres_q  <= pres_d;
      dup_q   <= dup_d;
      err_q   <= err_d;
      ok_q    <= ok_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
`ifdef BALLOT_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.np        = pres_q[31:0];
  assign bus.vip       = pres_q[39:32];
  assign bus.vvip      = pres_q[40];
  assign bus.busy      = busy_q;
  assign bus.frame_ok  = ok_q;
  assign bus.frame_err = ferr_q;
  assign bus.dup_cnt   = dup_q;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_ballot_rx.sv
// Bench for ballot_rx: directed scenarios plus randomized frames checked against a voter-set model.
// Latency: n/a. Backpressure: n/a.
// Follows BALLOT_PARITY_EN the same way as the design (frame length and parity handling).
module tb_ballot_rx;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef BALLOT_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int FLEN   = 9;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int FLEN   = 8;
`endif

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ballot_rx_if #(.CNT_W(CNT_W)) bus ();
  ballot_rx #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: set of voters seen, plus plain saturating tallies.
  bit seen [41];
  int m_dup;
  int m_err;
  bit pulse_at_stop;

  function automatic void model_clear();
    foreach (seen[i]) seen[i] = 1'b0;
    m_dup = 0;
    m_err = 0;
  endfunction

  // Returns 0 = accepted, 1 = duplicate, 2 = rejected.
  function automatic int model_frame(int id, bit bad_par, bit bad_stop);
    if (bad_stop || (PAR_EN && bad_par) || id > 40) begin
      if (m_err < CMAX) m_err++;
      return 2;
    end
    if (seen[id]) begin
      if (m_dup < CMAX) m_dup++;
      return 1;
    end
    seen[id] = 1'b1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_np();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = seen[i];
    return v;
  endfunction

  function automatic logic [7:0] exp_vip();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = seen[32+i];
    return v;
  endfunction

  // Drives one frame, one bit per negedge. Returns right after the stop bit is driven;
  // the evaluation result is visible at the following negedge.
  task automatic send_bits(input logic [5:0] id, input bit bad_par, input bit bad_stop,
                           input bit start_driven, input bit clr_at_stop);
    if (!start_driven) begin
      @(negedge clk);
      bus.sin = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.sin = id[i];
    end
    if (PAR_EN) begin
      @(negedge clk);
      bus.sin = (^id) ^ bad_par;
    end
    @(negedge clk);
    pulse_at_stop = bus.frame_ok | bus.frame_err;
    bus.sin = ~bad_stop;
    if (clr_at_stop) bus.clr = 1'b1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.sin = 1'b1;
    bus.clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (bus.np !== 32'h0) begin n_bad++; $display("FAIL reset_np got %h exp 0", bus.np); end
    n_vec++; if (bus.vip !== 8'h0 || bus.vvip !== 1'b0) begin n_bad++; $display("FAIL reset_vip got %h/%b exp 0/0", bus.vip, bus.vvip); end
    n_vec++; if (bus.busy !== 1'b0 || bus.frame_ok !== 1'b0 || bus.frame_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags got busy=%b ok=%b err=%b exp 0", bus.busy, bus.frame_ok, bus.frame_err); end
    n_vec++; if (bus.dup_cnt !== 8'd0 || bus.err_cnt !== 8'd0) begin
      n_bad++; $display("FAIL reset_cnt got dup=%0d err=%0d exp 0", bus.dup_cnt, bus.err_cnt); end
  endtask

  task automatic test_single();
    do_reset();
    void'(model_frame(5, 1'b0, 1'b0));
    send_bits(6'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (pulse_at_stop !== 1'b0) begin n_bad++; $display("FAIL single_early got pulse=1 exp 0"); end
    @(negedge clk);
    bus.sin = 1'b1;
    n_vec++; if (bus.frame_ok !== 1'b1 || bus.frame_err !== 1'b0) begin
      n_bad++; $display("FAIL single_pulse got ok=%b err=%b exp 1/0", bus.frame_ok, bus.frame_err); end
    n_vec++; if (bus.np !== 32'h0000_0020 || bus.np !== exp_np()) begin
      n_bad++; $display("FAIL single_np got %h exp %h", bus.np, exp_np()); end
    n_vec++; if (bus.err_cnt !== 8'd0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL single_idle got err_cnt=%0d busy=%b exp 0/0", bus.err_cnt, bus.busy); end
    @(negedge clk);
    n_vec++; if (bus.frame_ok !== 1'b0) begin n_bad++; $display("FAIL single_width got ok=%b exp 0", bus.frame_ok); end
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    do_reset();
    void'(model_frame(33, 1'b0, 1'b0));
    void'(model_frame(40, 1'b0, 1'b0));
    send_bits(6'd33, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    c1 = cyc;
    n_vec++; if (bus.frame_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_ok1 got %b exp 1", bus.frame_ok); end
    bus.sin = 1'b0;
    send_bits(6'd40, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    c2 = cyc;
    bus.sin = 1'b1;
    n_vec++; if (bus.frame_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_ok2 got %b exp 1", bus.frame_ok); end
    n_vec++; if (c2 - c1 != FLEN) begin n_bad++; $display("FAIL b2b_gap got %0d exp %0d", c2 - c1, FLEN); end
    n_vec++; if (bus.vip !== 8'h02 || bus.vvip !== 1'b1 || bus.np !== 32'h0) begin
      n_bad++; $display("FAIL b2b_vec got vip=%h vvip=%b np=%h exp 02/1/0", bus.vip, bus.vvip, bus.np); end
  endtask

  task automatic test_dup();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      void'(model_frame(5, 1'b0, 1'b0));
      send_bits(6'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      bus.sin = 1'b1;
      n_vec++; if (bus.frame_ok !== (k == 0) || bus.frame_err !== 1'b0) begin
        n_bad++; $display("FAIL dup_pulse%0d got ok=%b err=%b exp %b/0", k, bus.frame_ok, bus.frame_err, k == 0); end
    end
    n_vec++; if (bus.np !== 32'h20 || bus.dup_cnt !== 8'd1 || bus.dup_cnt !== m_dup[7:0]) begin
      n_bad++; $display("FAIL dup_state got np=%h dup=%0d exp 20/1", bus.np, bus.dup_cnt); end
  endtask

  task automatic test_errors();
    logic [5:0] ids [3];
    bit bp [3];
    bit bs [3];
    int r;
    ids = '{6'd45, 6'd5, 6'd7};
    bp  = '{1'b0, 1'b1, 1'b0};
    bs  = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      r = model_frame(int'(ids[k]), bp[k], bs[k]);
      send_bits(ids[k], bp[k], bs[k], 1'b0, 1'b0);
      @(negedge clk);
      bus.sin = 1'b1;
      n_vec++; if (bus.frame_err !== (r == 2) || bus.frame_ok !== (r == 0)) begin
        n_bad++; $display("FAIL err_pulse%0d got err=%b ok=%b exp %b/%b", k, bus.frame_err, bus.frame_ok, r == 2, r == 0); end
    end
    n_vec++; if (bus.err_cnt !== m_err[7:0] || (PAR_EN && bus.err_cnt !== 8'd3)) begin
      n_bad++; $display("FAIL err_cnt got %0d exp %0d", bus.err_cnt, m_err); end
    n_vec++; if (bus.np !== exp_np() || bus.vip !== 8'h0 || bus.vvip !== 1'b0) begin
      n_bad++; $display("FAIL err_vec got np=%h vip=%h vvip=%b exp %h/0/0", bus.np, bus.vip, bus.vvip, exp_np()); end
  endtask

  task automatic test_clr();
    do_reset();
    void'(model_frame(3, 1'b0, 1'b0));
    send_bits(6'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.sin = 1'b1;
    n_vec++; if (bus.np !== 32'h8) begin n_bad++; $display("FAIL clr_pre got np=%h exp 8", bus.np); end
    send_bits(6'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus.clr = 1'b0;
    bus.sin = 1'b1;
    model_clear();
    n_vec++; if (bus.frame_ok !== 1'b0 || bus.frame_err !== 1'b0) begin
      n_bad++; $display("FAIL clr_pulse got ok=%b err=%b exp 0/0", bus.frame_ok, bus.frame_err); end
    n_vec++; if (bus.np !== 32'h0 || bus.vip !== 8'h0 || bus.vvip !== 1'b0 || bus.dup_cnt !== 8'd0 || bus.err_cnt !== 8'd0) begin
      n_bad++; $display("FAIL clr_state got np=%h dup=%0d err=%0d exp all 0", bus.np, bus.dup_cnt, bus.err_cnt); end
    void'(model_frame(9, 1'b0, 1'b0));
    send_bits(6'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.sin = 1'b1;
    n_vec++; if (bus.np !== 32'h0000_0200 || bus.frame_ok !== 1'b1) begin
      n_bad++; $display("FAIL clr_resend got np=%h ok=%b exp 00000200/1", bus.np, bus.frame_ok); end
  endtask

  task automatic test_saturate();
    logic [5:0] id;
    bit bs;
    int r;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      bs = ($urandom_range(0, 1) == 1);
      id = bs ? 6'($urandom_range(0, 63)) : 6'($urandom_range(41, 63));
      r  = model_frame(int'(id), 1'b0, bs);
      send_bits(id, 1'b0, bs, k != 0, 1'b0);
      @(negedge clk);
      n_vec++; if (bus.frame_err !== (r == 2)) begin
        n_bad++; $display("FAIL sat_pulse%0d got %b exp %b", k, bus.frame_err, r == 2); end
      bus.sin = 1'b0;
    end
    bus.sin = 1'b1;
    n_vec++; if (bus.err_cnt !== 8'd255 || m_err != 255) begin
      n_bad++; $display("FAIL sat_cnt got %0d exp 255", bus.err_cnt); end
    n_vec++; if (bus.np !== 32'h0 || bus.vip !== 8'h0 || bus.vvip !== 1'b0) begin
      n_bad++; $display("FAIL sat_vec got np=%h vip=%h exp 0/0", bus.np, bus.vip); end
  endtask

  task automatic test_random();
    logic [5:0] id;
    bit bp, bs, b2b;
    int r;
    do_reset();
    b2b = 1'b0;
    for (int k = 0; k < 80; k++) begin
      id = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 40));
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 9) == 0);
      r  = model_frame(int'(id), bp, bs);
      send_bits(id, bp, bs, b2b, 1'b0);
      @(negedge clk);
      b2b = ($urandom_range(0, 1) == 1);
      bus.sin = ~b2b;
      n_vec++; if (bus.frame_ok !== (r == 0) || bus.frame_err !== (r == 2)) begin
        n_bad++; $display("FAIL rand_pulse%0d id=%0d got ok=%b err=%b exp %b/%b", k, id, bus.frame_ok, bus.frame_err, r == 0, r == 2); end
      n_vec++; if (bus.np !== exp_np() || bus.vip !== exp_vip() || bus.vvip !== seen[40]) begin
        n_bad++; $display("FAIL rand_vec%0d got %h/%h/%b exp %h/%h/%b", k, bus.np, bus.vip, bus.vvip, exp_np(), exp_vip(), seen[40]); end
      n_vec++; if (bus.dup_cnt !== m_dup[7:0] || bus.err_cnt !== m_err[7:0]) begin
        n_bad++; $display("FAIL rand_cnt%0d got dup=%0d err=%0d exp %0d/%0d", k, bus.dup_cnt, bus.err_cnt, m_dup, m_err); end
    end
    if (b2b) begin
      // Finish the frame whose start bit is already on the line so the next test starts clean.
      void'(model_frame(0, 1'b0, 1'b0));
      send_bits(6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      bus.sin = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    // Leave something in the vectors so the reset has state to clear.
    void'(model_frame(1, 1'b0, 1'b0));
    send_bits(6'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.sin = 1'b1;
    @(negedge clk);
    bus.sin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.sin = 1'b1;
    end
    n_vec++; if (bus.busy !== 1'b1 || bus.np[1] !== 1'b1) begin
      n_bad++; $display("FAIL mid_busy got busy=%b np1=%b exp 1/1", bus.busy, bus.np[1]); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.np !== 32'h0 || bus.vip !== 8'h0 || bus.vvip !== 1'b0 || bus.busy !== 1'b0 ||
                 bus.frame_ok !== 1'b0 || bus.frame_err !== 1'b0 || bus.dup_cnt !== 8'd0 || bus.err_cnt !== 8'd0) begin
      n_bad++; $display("FAIL mid_reset got np=%h busy=%b dup=%0d err=%0d exp all 0", bus.np, bus.busy, bus.dup_cnt, bus.err_cnt); end
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    void'(model_frame(12, 1'b0, 1'b0));
    send_bits(6'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.sin = 1'b1;
    n_vec++; if (bus.np !== 32'h0000_1000 || bus.frame_ok !== 1'b1) begin
      n_bad++; $display("FAIL mid_after got np=%h ok=%b exp 00001000/1", bus.np, bus.frame_ok); end
  endtask

  initial begin
    reset   = 1'b1;
    bus.sin = 1'b1;
    bus.clr = 1'b0;
    model_clear();
    test_reset();
    test_single();
    test_back_to_back();
    test_dup();
    test_errors();
    test_clr();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
